// File: rtl/decoder_code_sequencer_if.sv
// rtl/decoder_code_sequencer_if.sv - button inputs and select-code outputs of the code sequencer
interface decoder_code_sequencer_if;
  logic       btn_step;
  logic       btn_mode;
  logic       dir;
  logic [1:0] code_out;
  logic       auto_active;
  logic       step_pulse;

  modport master (
    output btn_step,
    output btn_mode,
    output dir,
    input  code_out,
    input  auto_active,
    input  step_pulse
  );

  modport slave (
    input  btn_step,
    input  btn_mode,
    input  dir,
    output code_out,
    output auto_active,
    output step_pulse
  );
endinterface

// File: rtl/decoder_code_sequencer.sv
// rtl/decoder_code_sequencer.sv - debounced button to 2-bit decoder select code, manual step or auto advance
module decoder_code_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_PERIOD     = 50000000
) (
  input logic                     clk,
  input logic                     rst,
  decoder_code_sequencer_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AP_W = $clog2(AUTO_PERIOD);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [AP_W-1:0] AP_MAX = AP_W'(AUTO_PERIOD - 1);

  localparam logic [0:0] ST_MANUAL = 1'b0;
  localparam logic [0:0] ST_AUTO   = 1'b1;

  // Bit 0 = step button, bit 1 = mode button throughout the input path.
  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      fill;
  logic [1:0]      deb;
  logic [1:0]      deb_d;
  logic [1:0]      armed;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  logic [0:0]      state;
  logic [AP_W-1:0] presc;
  logic [1:0]      code_q;
  logic [1:0]      code_next;
  logic            step_q;
  logic            step_ev;
  logic            mode_ev;
  logic            terminal;
  logic            advance;

  assign raw = {bus.btn_mode, bus.btn_step};

  // Two-flop synchronisers; fill marks when sync2 holds a real post-reset sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      fill  <= 2'b00;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
    end
  end

  // Debounce: level flips only after the synchronised level has differed for DEBOUNCE_CYCLES+1 samples.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        db_cnt[i] <= '0;
        deb[i]    <= 1'b0;
      end else if (sync2[i] != deb[i]) begin
        if (db_cnt[i] == DB_MAX) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end else begin
        db_cnt[i] <= '0;
      end
    end
  end

  // A button held through reset must be seen released before its presses count.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_d <= 2'b00;
      armed <= 2'b00;
    end else begin
      deb_d <= deb;
      armed <= armed | ({2{fill[1]}} & ~sync2 & ~deb);
    end
  end

  assign press   = deb & ~deb_d & armed;
  assign step_ev = press[0];
  assign mode_ev = press[1];

  assign terminal  = (state == ST_AUTO) && (presc == AP_MAX);
  assign advance   = ((state == ST_MANUAL) && step_ev) || terminal;
  assign code_next = bus.dir ? (code_q - 2'd1) : (code_q + 2'd1);

  // Code register; step_pulse marks the cycle after every code change.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= 2'b00;
      step_q <= 1'b0;
    end else begin
      step_q <= advance;
      if (advance) begin
        code_q <= code_next;
      end
    end
  end

  // Mode FSM and AUTO prescaler; a terminal advance still lands on the exit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_MANUAL;
      presc <= '0;
    end else begin
      case (state)
        ST_MANUAL: begin
          if (mode_ev) begin
            state <= ST_AUTO;
            presc <= '0;
          end
        end
        ST_AUTO: begin
          if (terminal) begin
            presc <= '0;
          end else begin
            presc <= presc + 1'b1;
          end
          if (mode_ev) begin
            state <= ST_MANUAL;
          end
        end
        default: begin
          state <= ST_MANUAL;
          presc <= '0;
        end
      endcase
    end
  end

  assign bus.code_out    = code_q;
  assign bus.auto_active = (state == ST_AUTO);
  assign bus.step_pulse  = step_q;

endmodule
